// File: rtl/isa_io_slave_sequencer.sv
// ISA I/O slave cycle sequencer: decodes an 8-byte I/O window and sequences the transceiver and local strobes.
// Optional macro ISA_IOCHRDY_EN enables IOCHRDY wait-state insertion on reads.
module isa_io_slave_sequencer #(
  parameter logic [9:0]  BASE_ADDR   = 10'h300,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] isa_addr,
  input  logic       isa_aen,
  input  logic       isa_ior_n,
  input  logic       isa_iow_n,
  output logic       xcvr_cs_n,
  output logic       xcvr_dce,
  output logic       iochrdy_oe,
  output logic [2:0] reg_addr,
  output logic       rd_strobe,
  output logic       wr_strobe,
  input  logic       rd_valid,
  output logic       cycle_err
);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DRIVE,
    WR_LATCH,
    WR_DONE,
    HOLD
  } state_t;

  state_t     state_q;
  logic       ior_s1_q, ior_s2_q, iow_s1_q, iow_s2_q;
  logic [1:0] sync_vld_q;
  logic       armed_q;
  logic       cs_n_q, dce_q, rdy_q, rd_stb_q, wr_stb_q, err_q;
  logic [2:0] reg_addr_q;
  logic       ior_act, iow_act, hit;

  assign ior_act = ~ior_s2_q;
  assign iow_act = ~iow_s2_q;
  assign hit     = ~isa_aen && (isa_addr[9:3] == BASE_ADDR[9:3]);

`ifdef ISA_IOCHRDY_EN
  logic [3:0] wait_cnt_q;
  logic [3:0] wait_cnt_d;
  assign wait_cnt_d = wait_cnt_q + 4'd1;
`else
  logic       unused_rd_valid;
  logic [3:0] unused_wait;
  assign unused_rd_valid = rd_valid;
  assign unused_wait     = WAIT_CYCLES[3:0];
`endif

  // sync_vld_q marks when the synchronizer outputs reflect real samples rather than
  // reset values; a strobe must be seen inactive on real samples before it can start a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ior_s1_q   <= 1'b1;
      ior_s2_q   <= 1'b1;
      iow_s1_q   <= 1'b1;
      iow_s2_q   <= 1'b1;
      sync_vld_q <= 2'b00;
      armed_q    <= 1'b0;
    end else begin
      ior_s1_q   <= isa_ior_n;
      ior_s2_q   <= ior_s1_q;
      iow_s1_q   <= isa_iow_n;
      iow_s2_q   <= iow_s1_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
      if (sync_vld_q[1] && !ior_act && !iow_act) begin
        armed_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cs_n_q     <= 1'b1;
      dce_q      <= 1'b0;
      rdy_q      <= 1'b0;
      reg_addr_q <= 3'd0;
      rd_stb_q   <= 1'b0;
      wr_stb_q   <= 1'b0;
      err_q      <= 1'b0;
`ifdef ISA_IOCHRDY_EN
      wait_cnt_q <= 4'd0;
`endif
    end else begin
      rd_stb_q <= 1'b0;
      wr_stb_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ior_act && iow_act) begin
            err_q   <= 1'b1;
            state_q <= HOLD;
          end else if (ior_act || iow_act) begin
            if (!hit || !armed_q) begin
              state_q <= HOLD;
            end else if (ior_act) begin
              reg_addr_q <= isa_addr[2:0];
              rd_stb_q   <= 1'b1;
              cs_n_q     <= 1'b0;
              dce_q      <= 1'b0;
`ifdef ISA_IOCHRDY_EN
              rdy_q      <= 1'b1;
              wait_cnt_q <= 4'd0;
              state_q    <= RD_WAIT;
`else
              state_q    <= RD_DRIVE;
`endif
            end else begin
              reg_addr_q <= isa_addr[2:0];
              cs_n_q     <= 1'b0;
              dce_q      <= 1'b1;
              state_q    <= WR_LATCH;
            end
          end
        end
        RD_WAIT: begin
`ifdef ISA_IOCHRDY_EN
          wait_cnt_q <= wait_cnt_d;
          if (rd_valid || (wait_cnt_d == WAIT_CYCLES[3:0])) begin
            rdy_q   <= 1'b0;
            state_q <= RD_DRIVE;
          end
`else
          state_q <= RD_DRIVE;
`endif
        end
        RD_DRIVE: begin
          if (!ior_act) begin
            cs_n_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        WR_LATCH: begin
          if (!iow_act) begin
            wr_stb_q <= 1'b1;
            state_q  <= WR_DONE;
          end
        end
        WR_DONE: begin
          cs_n_q  <= 1'b1;
          dce_q   <= 1'b0;
          state_q <= IDLE;
        end
        HOLD: begin
          if (!ior_act && !iow_act) begin
            state_q <= IDLE;
          end
        end
        default: begin
          cs_n_q  <= 1'b1;
          dce_q   <= 1'b0;
          rdy_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign xcvr_cs_n  = cs_n_q;
  assign xcvr_dce   = dce_q;
  assign iochrdy_oe = rdy_q;
  assign reg_addr   = reg_addr_q;
  assign rd_strobe  = rd_stb_q;
  assign wr_strobe  = wr_stb_q;
  assign cycle_err  = err_q;

endmodule

// File: tb/tb_isa_io_slave_sequencer.sv
// Self-checking bench for isa_io_slave_sequencer: directed cycles plus randomized ISA cycles
// compared against a cycle-timing model of the slave protocol.
module tb_isa_io_slave_sequencer;
  localparam logic [9:0] BASE  = 10'h300;
  localparam int         WAITC = 4;
`ifdef ISA_IOCHRDY_EN
  localparam bit RDY_EN = 1'b1;
`else
  localparam bit RDY_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] isa_addr = 10'd0;
  logic       isa_aen = 1'b0;
  logic       isa_ior_n = 1'b1;
  logic       isa_iow_n = 1'b1;
  logic       xcvr_cs_n, xcvr_dce, iochrdy_oe, rd_strobe, wr_strobe, cycle_err;
  logic [2:0] reg_addr;
  logic       rd_valid = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] m_reg = 3'd0;
  logic       m_err = 1'b0;

  isa_io_slave_sequencer #(.BASE_ADDR(BASE), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst_n(rst_n), .isa_addr(isa_addr), .isa_aen(isa_aen),
    .isa_ior_n(isa_ior_n), .isa_iow_n(isa_iow_n), .xcvr_cs_n(xcvr_cs_n),
    .xcvr_dce(xcvr_dce), .iochrdy_oe(iochrdy_oe), .reg_addr(reg_addr),
    .rd_strobe(rd_strobe), .wr_strobe(wr_strobe), .rd_valid(rd_valid),
    .cycle_err(cycle_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cs_n"}, {31'd0, xcvr_cs_n}, 32'd1);
    check({tag, "_dce"},  {31'd0, xcvr_dce}, 32'd0);
    check({tag, "_rdy"},  {31'd0, iochrdy_oe}, 32'd0);
    check({tag, "_stb"},  {30'd0, rd_strobe, wr_strobe}, 32'd0);
    check({tag, "_reg"},  {29'd0, reg_addr}, 32'd0);
    check({tag, "_err"},  {31'd0, cycle_err}, 32'd0);
  endtask

  // kind: 0 write, 1 read, 2 both strobes. Strobe(s) fall just after edge 0 and rise
  // just after edge len; rd_valid rises so that it is first sampled on edge dly+3.
  // Bit k of each vector is the output just after edge k.
  task automatic run_txn(input string tag, input int kind, input logic [9:0] addr,
                         input logic aen, input int len, input int dly);
    logic [31:0] o_cs, o_dce, o_rdy, o_rs, o_ws;
    logic [31:0] e_cs, e_dce, e_rdy, e_rs, e_ws;
    bit hit;
    int h, rel, n;
    hit = !aen && (addr[9:3] == BASE[9:3]);
    n = len + 16;
    e_cs = '0; e_dce = '0; e_rdy = '0; e_rs = '0; e_ws = '0;
    o_cs = '0; o_dce = '0; o_rdy = '0; o_rs = '0; o_ws = '0;
    // Strobe is seen by the sequencer 3 edges after the pin changes (two sync flops + decode).
    if (kind == 0 && hit) begin
      for (int k = 3; k <= len + 3; k++) begin
        e_cs[k] = 1'b1;
        e_dce[k] = 1'b1;
      end
      e_ws[len + 3] = 1'b1;
      m_reg = addr[2:0];
    end else if (kind == 1 && hit) begin
      h = RDY_EN ? ((dly < WAITC) ? dly : WAITC) : 0;
      rel = (len + 3 > h + 4) ? len + 3 : h + 4;
      for (int k = 3; k < rel; k++) e_cs[k] = 1'b1;
      for (int k = 3; k < 3 + h; k++) e_rdy[k] = 1'b1;
      e_rs[3] = 1'b1;
      m_reg = addr[2:0];
    end else if (kind == 2) begin
      m_err = 1'b1;
    end
    isa_addr = addr;
    isa_aen  = aen;
    if (kind != 1) isa_iow_n = 1'b0;
    if (kind != 0) isa_ior_n = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      o_cs[k]  = ~xcvr_cs_n;
      o_dce[k] = xcvr_dce;
      o_rdy[k] = iochrdy_oe;
      o_rs[k]  = rd_strobe;
      o_ws[k]  = wr_strobe;
      if (k == len) begin
        isa_ior_n = 1'b1;
        isa_iow_n = 1'b1;
      end
      if (kind == 1 && k == dly + 2) rd_valid = 1'b1;
    end
    rd_valid = 1'b0;
    check({tag, "_cs"},  o_cs,  e_cs);
    check({tag, "_dce"}, o_dce, e_dce);
    check({tag, "_rdy"}, o_rdy, e_rdy);
    check({tag, "_rds"}, o_rs,  e_rs);
    check({tag, "_wrs"}, o_ws,  e_ws);
    check({tag, "_reg"}, {29'd0, reg_addr}, {29'd0, m_reg});
    check({tag, "_err"}, {31'd0, cycle_err}, {31'd0, m_err});
    $display("txn %s kind=%0d addr=%h aen=%0d len=%0d dly=%0d hit=%0d", tag, kind, addr, aen, len, dly, hit);
  endtask

  initial begin
    int kind, len, dly;
    logic [9:0] addr;
    logic aen;
    logic [31:0] o_rs, o_cs;

    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    run_txn("wr305", 0, 10'h305, 1'b0, 10, 1);
    run_txn("rd302", 1, 10'h302, 1'b0, 10, 2);
    run_txn("rd300_to", 1, 10'h300, 1'b0, 10, 30);
    run_txn("rd308_miss", 1, 10'h308, 1'b0, 6, 1);
    run_txn("wr301_aen", 0, 10'h301, 1'b1, 6, 1);
    run_txn("wr306_short", 0, 10'h306, 1'b0, 1, 1);
    run_txn("rd307_short", 1, 10'h307, 1'b0, 1, 6);
    run_txn("both300", 2, 10'h300, 1'b0, 5, 1);
    run_txn("wr304_after_err", 0, 10'h304, 1'b0, 4, 1);

    for (int i = 0; i < 30; i++) begin
      kind = ($urandom_range(0, 9) < 4) ? 0 : (($urandom_range(0, 9) == 0) ? 2 : 1);
      addr = ($urandom_range(0, 3) != 0) ? {BASE[9:3], 3'($urandom_range(0, 7))}
                                         : 10'($urandom_range(0, 1023));
      aen  = ($urandom_range(0, 7) == 0);
      len  = $urandom_range(1, 10);
      dly  = $urandom_range(1, 6);
      run_txn($sformatf("rnd%0d", i), kind, addr, aen, len, dly);
    end

    // Reset in the middle of a read with ior held low.
    isa_addr = 10'h303;
    isa_aen  = 1'b0;
    isa_ior_n = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle("midrst");
    m_reg = 3'd0;
    m_err = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    o_rs = '0;
    o_cs = '0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      o_rs[k] = rd_strobe;
      o_cs[k] = ~xcvr_cs_n;
    end
    check("held_ior_rds", o_rs, 32'd0);
    check("held_ior_cs", o_cs, 32'd0);
    $display("txn held_ior after reset release, ior_n held low 10 clocks");
    isa_ior_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    run_txn("rd303_fresh", 1, 10'h303, 1'b0, 5, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/isa_io_slave_sequencer.md
ISA_IO_SLAVE_SEQUENCER -- requirements
Module: isa_io_slave_sequencer

Interface
REQ-001 Parameter BASE_ADDR, default 10'h300: ISA I/O base address; 8-byte window BASE_ADDR[9:3].
REQ-002 Parameter WAIT_CYCLES, default 4: maximum wait-state clocks for a read before forced completion (1..15).
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 isa_addr  in  10  ISA SA[9:0].
REQ-006 isa_aen  in  1  ISA AEN; 1 = DMA cycle, decode disabled.
REQ-007 isa_ior_n / isa_iow_n  in  1 each  ISA I/O read / write strobes, asynchronous, active-low.
REQ-008 xcvr_cs_n  out  1  chip select to the 82x6 data-bus transceiver pair, active-low.
REQ-009 xcvr_dce  out  1  transceiver direction: 1 = ISA bus -> local (write), 0 = local -> ISA bus (read).
REQ-010 iochrdy_oe  out  1  1 = pull ISA IOCHRDY low (insert wait state).
REQ-011 reg_addr  out  3  latched register offset isa_addr[2:0].
REQ-012 rd_strobe / wr_strobe  out  1 each  one-clock local read / write request pulses.
REQ-013 rd_valid  in  1  local side has driven read data onto the transceiver inputs.
REQ-014 cycle_err  out  1  sticky: both strobes were seen low together; cleared only by reset.

Function
REQ-015 ior_n and iow_n SHALL each pass through a 2-flop synchronizer; "strobe active" means the synchronized value is 0.
REQ-016 Decode hit SHALL mean isa_aen==0 and isa_addr[9:3]==BASE_ADDR[9:3], sampled in IDLE on the clock where a synchronized strobe is first seen active.
REQ-017 FSM states SHALL be IDLE, RD_WAIT, RD_DRIVE, WR_LATCH, WR_DONE and HOLD.
REQ-018 IDLE: xcvr_cs_n=1, xcvr_dce=0, iochrdy_oe=0, strobes 0.
REQ-019 IDLE to RD_WAIT on hit with only ior active: latch reg_addr, pulse rd_strobe for exactly one clock, assert xcvr_cs_n=0 with xcvr_dce=0, and assert iochrdy_oe.
REQ-020 RD_WAIT SHALL count clocks from 0; it moves to RD_DRIVE when rd_valid==1 or when the count reaches WAIT_CYCLES, whichever comes first; iochrdy_oe is deasserted on entry to RD_DRIVE.
REQ-021 RD_DRIVE SHALL hold xcvr_cs_n=0 and xcvr_dce=0 until synchronized ior goes inactive, then go to IDLE with xcvr_cs_n=1 on that same clock.
REQ-022 IDLE to WR_LATCH on hit with only iow active: latch reg_addr, assert xcvr_cs_n=0 and xcvr_dce=1, and keep iochrdy_oe=0.
REQ-023 WR_LATCH SHALL wait for synchronized iow inactive, then pulse wr_strobe for one clock while xcvr_cs_n is still 0, and enter WR_DONE.
REQ-024 WR_DONE SHALL release xcvr_cs_n=1 and restore xcvr_dce=0 on the next clock, then return to IDLE.
REQ-025 A miss (address or aen) with a strobe active SHALL go to HOLD with all outputs idle; HOLD returns to IDLE when both strobes are inactive.
REQ-026 Both strobes active in IDLE SHALL set cycle_err and go to HOLD; no strobe is issued.
REQ-027 xcvr_dce SHALL change only while xcvr_cs_n==1 or on the clock cs_n is asserted, never mid-select.
REQ-028 At most one rd_strobe and one wr_strobe SHALL be issued per ISA cycle.

Reset
REQ-029 Asserting rst_n low SHALL force, asynchronously: state IDLE, xcvr_cs_n=1, xcvr_dce=0, iochrdy_oe=0, reg_addr=0, rd_strobe=0, wr_strobe=0, cycle_err=0, synchronizers=1, wait count=0.
REQ-030 Reset in mid-cycle SHALL abandon the cycle; after release, a strobe still held active SHALL be treated as a fresh edge only after it is seen inactive first (HOLD path).

Configuration
REQ-031 Macro ISA_IOCHRDY_EN defined: wait states are inserted as in REQ-019 and REQ-020.
REQ-032 ISA_IOCHRDY_EN undefined: iochrdy_oe is tied to 0, RD_WAIT is bypassed (IDLE goes directly to RD_DRIVE with rd_strobe pulsed), and rd_valid is ignored.

Verification
REQ-033 Write to 0x305 (aen=0, iow_n low 10 clocks) -> xcvr_cs_n=0 and dce=1 from 3 clocks after iow_n falls; reg_addr=5; one wr_strobe after iow_n rises; cs_n=1 one clock later.
REQ-034 Read from 0x302, rd_valid raised 2 clocks after rd_strobe -> iochrdy_oe high for 2 clocks then low; dce=0 and cs_n=0 until ior_n rises.
REQ-035 Read from 0x300 with rd_valid never raised, WAIT_CYCLES=4 -> iochrdy_oe released after 4 clocks; cycle completes normally.
REQ-036 Read from 0x308, and write to 0x301 with aen=1 -> no strobes; cs_n stays 1; FSM passes through HOLD.
REQ-037 ior_n and iow_n both low at 0x300 -> cycle_err=1, no strobes; it remains 1 until rst_n pulse.
REQ-038 rst_n pulsed low during RD_WAIT while ior_n is held low -> all outputs idle immediately; no new rd_strobe until ior_n rises and falls again.
